keypad_cmd_scanner: RTL and testbench
=====================================

Name: keypad_cmd_scanner

Overview:
- Front-end stage of the OMOK game: scans the 4x3 matrix keypad, debounces it, decodes the key and issues one game command per physical press.
- Drives `key_row` and reads `key_col`.
- Hands the command (up/left/put/right/undo/down) to the game FSM, which owns the cursor and the 10x10 board, through a valid/ready handshake.

Parameters:
- SCAN_DIV, 1000: clock cycles each row is driven; must be >=4.
- DEBOUNCE_FRAMES, 4: consecutive identical full-keypad frames required to accept a press or a release; must be >=1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- key_col  in  3  keypad column sense, asynchronous; bit2=left column, bit0=right column
- key_row  out  4  one-hot row drive; 4'b1000 = top row (keys 1,2,3)
- cmd_valid  out  1  command available
- cmd_ready  in  1  consumer accepts the command
- cmd  out  3  command code
- key_value  out  4  last debounced key code; 4'hf = none
- key_held  out  1  a debounced key is currently held

Behaviour:
- Reset (rst low at a clk edge) puts every output in a fixed state:
  - key_row=4'b1000, cmd_valid=0, cmd=3'd6, key_value=4'hf, key_held=0.
  - Divider, frame accumulator, debounce counter and synchronizer flops are all cleared.
  - Reset mid-frame or mid-handshake discards the pending command.
- key_col passes through a 2-flop synchronizer before any use.
- Row scan:
  - A divider counts 0..SCAN_DIV-1.
  - key_row rotates 1000 -> 0100 -> 0010 -> 0001 -> 1000 on divider wrap.
  - The synchronized col is sampled on divider count SCAN_DIV-1 of each row.
- Per-row decode (shared function):
  - Row 1000: col 100/010/001 -> 1/2/3.
  - Row 0100: -> 4/5/6.
  - Row 0010: -> 7/8/9.
  - Row 0001: -> c/0/d.
  - Col 000 or non-one-hot -> 4'hf for that row.
- Frame code:
  - A frame is the 4 row samples.
  - The frame code is the first non-f row code in scan order (top row wins); otherwise 4'hf.
  - The frame code is evaluated at the end of the 0001 row.
- Debounce:
  - If the frame code equals the previous frame code, stable_cnt increments, saturating at DEBOUNCE_FRAMES; otherwise it resets to 1.
  - When stable_cnt reaches DEBOUNCE_FRAMES and the frame code differs from key_value, key_value takes the frame code on the next cycle.
  - key_held = (key_value != 4'hf).
  - A transition directly from one key to another key is accepted as a new press; no release is required between them.
- Command map, applied on acceptance of a new non-f key_value:
  - 5 -> 0 (up), 7 -> 1 (left), 8 -> 2 (put), 9 -> 3 (right), d -> 4 (undo), 0 -> 5 (down).
  - Any other key updates key_value but issues no command.
- Handshake:
  - cmd_valid rises in the same cycle key_value updates.
  - cmd is held stable while cmd_valid=1.
  - The command retires on the cycle where cmd_valid && cmd_ready; cmd_valid falls next cycle and cmd returns to 3'd6.
  - At most one command is outstanding. A new accepted press while cmd_valid=1 is dropped (key_value still updates).
  - Holding a key never repeats the command.
- Latency: from the first fully clean frame, the command appears DEBOUNCE_FRAMES frames later plus 1 cycle. With cmd_ready=1 the command lasts exactly 1 cycle.

Decomposition:
- Package omok_pkg holds:
  - command codes CMD_UP..CMD_DOWN and CMD_NONE=3'd6;
  - key code constants, including KEY_NONE=4'hf;
  - row one-hot constants;
  - the row/col -> key_value decode function;
  - the key -> command map function.
- One sub-module, sync2: a generic 2-flop synchronizer, instantiated 3 bits wide.

Test Plan:
- All tests run with SCAN_DIV=4 and DEBOUNCE_FRAMES=2.
- Reset: hold rst=0 for 3 cycles -> key_row=1000, cmd_valid=0, cmd=6, key_value=f; after release key_row becomes 0100 after 4 cycles and returns to 1000 after 16.
- Press "9": drive col=001 whenever row=0010 for 3 frames, cmd_ready=1 -> exactly one cmd_valid pulse with cmd=3, key_value=9, key_held=1. Then release for 3 frames -> key_value=f, no further pulse.
- Bounce: col=010 on row 0100 in frame 1 only, absent in frame 2, present in frames 3-4 -> single cmd=0 issued only after frame 4, never after frame 1.
- Backpressure: cmd_ready=0, press "8" -> cmd_valid=1, cmd=2 held. Release, then press "7" -> still cmd=2, key_value=7. cmd_ready=1 -> one retire, then cmd_valid=0 and no cmd=1 issued.
- Priority and ignore: "5" and "0" held together -> cmd=0 (up). Press "1" alone -> key_value=1, no cmd_valid. Col=110 on any row -> treated as no key.
- Reset mid-handshake: cmd_valid=1 pending, rst=0 for 1 cycle -> cmd_valid=0, key_value=f next cycle. The still-held key is re-debounced and re-issued after 2 clean frames.

Source files
------------

// File: rtl/omok_pkg.sv
// Shared definitions for the OMOK keypad front end.
//
// Holds the game command codes, keypad key codes, row drive patterns, the
// row/column -> key decode used by the scanner, and the key -> command map.
// The consumer (game FSM) sees only cmd_t values; CMD_NONE marks "no command".
package omok_pkg;

    typedef logic [2:0] cmd_t;
    typedef logic [3:0] key_t;

    // Game commands handed to the board FSM
    localparam cmd_t CMD_UP    = 3'd0;
    localparam cmd_t CMD_LEFT  = 3'd1;
    localparam cmd_t CMD_PUT   = 3'd2;
    localparam cmd_t CMD_RIGHT = 3'd3;
    localparam cmd_t CMD_UNDO  = 3'd4;
    localparam cmd_t CMD_DOWN  = 3'd5;
    localparam cmd_t CMD_NONE  = 3'd6;

    // Key codes as printed on the 4x3 pad; c and d are the '*' and '#' keys
    localparam key_t KEY_0    = 4'h0;
    localparam key_t KEY_1    = 4'h1;
    localparam key_t KEY_2    = 4'h2;
    localparam key_t KEY_3    = 4'h3;
    localparam key_t KEY_4    = 4'h4;
    localparam key_t KEY_5    = 4'h5;
    localparam key_t KEY_6    = 4'h6;
    localparam key_t KEY_7    = 4'h7;
    localparam key_t KEY_8    = 4'h8;
    localparam key_t KEY_9    = 4'h9;
    localparam key_t KEY_C    = 4'hc;
    localparam key_t KEY_D    = 4'hd;
    localparam key_t KEY_NONE = 4'hf;

    // One-hot row drive, top row first in scan order
    localparam logic [3:0] ROW_TOP   = 4'b1000;
    localparam logic [3:0] ROW_UPPER = 4'b0100;
    localparam logic [3:0] ROW_LOWER = 4'b0010;
    localparam logic [3:0] ROW_BOT   = 4'b0001;

    // Column sense, bit2 is the left column
    localparam logic [2:0] COL_LEFT  = 3'b100;
    localparam logic [2:0] COL_MID   = 3'b010;
    localparam logic [2:0] COL_RIGHT = 3'b001;

    // Command handshake state
    typedef enum logic {
        StIdle,
        StValid
    } hs_state_e;

    // Decode one row sample. Anything but exactly one column active is
    // reported as no key, so a two-key chord inside one row is ignored.
    function automatic key_t decode_key(logic [3:0] row, logic [2:0] col);
        key_t k;
        k = KEY_NONE;
        case (row)
            ROW_TOP: begin
                case (col)
                    COL_LEFT:  k = KEY_1;
                    COL_MID:   k = KEY_2;
                    COL_RIGHT: k = KEY_3;
                    default:   k = KEY_NONE;
                endcase
            end
            ROW_UPPER: begin
                case (col)
                    COL_LEFT:  k = KEY_4;
                    COL_MID:   k = KEY_5;
                    COL_RIGHT: k = KEY_6;
                    default:   k = KEY_NONE;
                endcase
            end
            ROW_LOWER: begin
                case (col)
                    COL_LEFT:  k = KEY_7;
                    COL_MID:   k = KEY_8;
                    COL_RIGHT: k = KEY_9;
                    default:   k = KEY_NONE;
                endcase
            end
            ROW_BOT: begin
                case (col)
                    COL_LEFT:  k = KEY_C;
                    COL_MID:   k = KEY_0;
                    COL_RIGHT: k = KEY_D;
                    default:   k = KEY_NONE;
                endcase
            end
            default: k = KEY_NONE;
        endcase
        return k;
    endfunction

    // Keys that steer the game; every other key is display-only
    function automatic cmd_t cmd_map(key_t key);
        cmd_t c;
        case (key)
            KEY_5:   c = CMD_UP;
            KEY_7:   c = CMD_LEFT;
            KEY_8:   c = CMD_PUT;
            KEY_9:   c = CMD_RIGHT;
            KEY_D:   c = CMD_UNDO;
            KEY_0:   c = CMD_DOWN;
            default: c = CMD_NONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/keypad_cmd_scanner_if.sv
// Command channel between the keypad scanner and the game FSM.
//
// Signals:
//   cmd_valid  scanner -> game  a command is offered
//   cmd        scanner -> game  command code, stable while cmd_valid is high
//   cmd_ready  game -> scanner  command accepted on cmd_valid && cmd_ready
//
// Modports: master = scanner side, slave = game FSM side.
interface keypad_cmd_scanner_if;
    import omok_pkg::*;

    logic cmd_valid;
    logic cmd_ready;
    cmd_t cmd;

    modport master (
        output cmd_valid,
        output cmd,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd,
        output cmd_ready
    );

endinterface

// File: rtl/sync2.sv
// Generic two-flop synchronizer for asynchronous level inputs.
//
// Ports:
//   clk  destination clock
//   rst  synchronous active-low reset, clears both stages
//   d    asynchronous input
//   q    synchronized output, two clk cycles behind d
module sync2 #(
    parameter int unsigned Width = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [Width-1:0] d,
    output logic [Width-1:0] q
);

    logic [Width-1:0] meta_q;
    logic [Width-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_cmd_scanner.sv
// OMOK keypad front end: scans a 4x3 matrix keypad, debounces whole-pad
// frames and issues one game command per physical press.
//
// Parameters:
//   SCAN_DIV         cycles each row is driven (>= 4, covers the synchronizer)
//   DEBOUNCE_FRAMES  identical frames needed to accept a press/release (>= 1)
//
// Ports:
//   clk        system clock
//   rst        synchronous active-low reset
//   key_col    asynchronous column sense, bit2 = left column
//   key_row    one-hot row drive, 4'b1000 = top row (1,2,3)
//   cmd_bus    master side of the command handshake (cmd_valid/cmd/cmd_ready)
//   key_value  last debounced key, 4'hf when nothing is held
//   key_held   a debounced key is currently held
module keypad_cmd_scanner
    import omok_pkg::*;
#(
    parameter int unsigned SCAN_DIV        = 1000,
    parameter int unsigned DEBOUNCE_FRAMES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2:0]           key_col,
    output logic [3:0]           key_row,
    keypad_cmd_scanner_if.master cmd_bus,
    output logic [3:0]           key_value,
    output logic                 key_held
);

    localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CntW = $clog2(DEBOUNCE_FRAMES + 1);

    logic [2:0]      col_sync;

    logic [DivW-1:0] div_q, div_d;
    logic [3:0]      row_q, row_d;
    key_t            acc_q, acc_d;
    key_t            prev_q, prev_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    key_t            key_value_q, key_value_d;
    hs_state_e       state_q, state_d;
    cmd_t            cmd_q, cmd_d;

    logic            div_last;
    logic            frame_end;
    logic            accept;
    logic            issue;
    key_t            row_code;
    key_t            frame_code;
    cmd_t            new_cmd;

    sync2 #(
        .Width (3)
    ) u_col_sync (
        .clk (clk),
        .rst (rst),
        .d   (key_col),
        .q   (col_sync)
    );

    // ------------------------------------------------------------------
    // Row scan: each row is driven for SCAN_DIV cycles and sampled on the
    // last one, giving the synchronizer time to settle after the switch.
    // ------------------------------------------------------------------
    always_comb begin : scan_comb
        div_last = (div_q == DivW'(SCAN_DIV - 1));
        div_d    = div_last ? '0 : div_q + DivW'(1);
        row_d    = div_last ? {row_q[0], row_q[3:1]} : row_q;
    end

    // ------------------------------------------------------------------
    // Frame accumulation: keep the first non-empty row code of the frame so
    // the upper row wins when keys in different rows are held together.
    // The top-row sample starts a fresh frame regardless of acc_q.
    // ------------------------------------------------------------------
    always_comb begin : frame_comb
        row_code   = decode_key(row_q, col_sync);
        frame_code = ((row_q == ROW_TOP) || (acc_q == KEY_NONE)) ? row_code : acc_q;
        frame_end  = div_last && (row_q == ROW_BOT);
        acc_d      = acc_q;
        if (div_last) begin
            acc_d = frame_end ? KEY_NONE : frame_code;
        end
    end

    // ------------------------------------------------------------------
    // Debounce: count consecutive identical frames. Once the count is
    // saturated, any disagreement between the stable code and key_value is
    // taken over, so key-to-key changes need no release in between.
    // ------------------------------------------------------------------
    always_comb begin : debounce_comb
        prev_d = prev_q;
        cnt_d  = cnt_q;
        if (frame_end) begin
            prev_d = frame_code;
            if (frame_code != prev_q) begin
                cnt_d = CntW'(1);
            end else if (cnt_q != CntW'(DEBOUNCE_FRAMES)) begin
                cnt_d = cnt_q + CntW'(1);
            end
        end

        accept      = (cnt_q == CntW'(DEBOUNCE_FRAMES)) && (prev_q != key_value_q);
        key_value_d = accept ? prev_q : key_value_q;
        new_cmd     = cmd_map(prev_q);
        // A release maps to CMD_NONE, so only real presses issue commands
        issue       = accept && (new_cmd != CMD_NONE);
    end

    always_ff @(posedge clk) begin : datapath_reg
        if (!rst) begin
            div_q       <= '0;
            row_q       <= ROW_TOP;
            acc_q       <= KEY_NONE;
            prev_q      <= KEY_NONE;
            cnt_q       <= '0;
            key_value_q <= KEY_NONE;
        end else begin
            div_q       <= div_d;
            row_q       <= row_d;
            acc_q       <= acc_d;
            prev_q      <= prev_d;
            cnt_q       <= cnt_d;
            key_value_q <= key_value_d;
        end
    end

    // ------------------------------------------------------------------
    // Command handshake FSM. A single slot: presses accepted while a
    // command is outstanding are dropped rather than queued.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin : hs_state_reg
        if (!rst) begin
            state_q <= StIdle;
            cmd_q   <= CMD_NONE;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
        end
    end

    always_comb begin : hs_next_comb
        state_d = state_q;
        cmd_d   = cmd_q;
        case (state_q)
            StIdle: begin
                if (issue) begin
                    state_d = StValid;
                    cmd_d   = new_cmd;
                end
            end
            StValid: begin
                if (cmd_bus.cmd_ready) begin
                    state_d = StIdle;
                    cmd_d   = CMD_NONE;
                end
            end
            default: begin
                state_d = StIdle;
                cmd_d   = CMD_NONE;
            end
        endcase
    end

    always_comb begin : hs_out_comb
        cmd_bus.cmd_valid = (state_q == StValid);
        cmd_bus.cmd       = cmd_q;
    end

    assign key_row   = row_q;
    assign key_value = key_value_q;
    assign key_held  = (key_value_q != KEY_NONE);

endmodule

// File: tb/tb_keypad_cmd_scanner.sv
// Directed bench for keypad_cmd_scanner with SCAN_DIV=4, DEBOUNCE_FRAMES=2.
// A behavioural keypad drives key_col from key_row and the per-row column
// masks pr0..pr3 (pr0 = top row). Frames are 16 cycles; the frame task keeps
// stimulus aligned to the start of the top row.
module tb_keypad_cmd_scanner;
    import omok_pkg::*;

    localparam int unsigned SCAN_DIV        = 4;
    localparam int unsigned DEBOUNCE_FRAMES = 2;
    localparam int unsigned FRAME           = 4 * SCAN_DIV;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] key_col;
    logic [3:0] key_row;
    logic [3:0] key_value;
    logic       key_held;
    logic [2:0] pr0, pr1, pr2, pr3;

    int   checks     = 0;
    int   errors     = 0;
    int   rise_cnt   = 0;
    int   retire_cnt = 0;
    cmd_t last_cmd   = CMD_NONE;
    logic prev_valid = 1'b0;

    keypad_cmd_scanner_if cmd_bus ();

    keypad_cmd_scanner #(
        .SCAN_DIV        (SCAN_DIV),
        .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_col   (key_col),
        .key_row   (key_row),
        .cmd_bus   (cmd_bus),
        .key_value (key_value),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    always_comb begin
        key_col = 3'b000;
        if (key_row[3]) key_col = pr0;
        else if (key_row[2]) key_col = pr1;
        else if (key_row[1]) key_col = pr2;
        else if (key_row[0]) key_col = pr3;
    end

    // Count cmd_valid rising edges and retirements
    always @(posedge clk) begin
        if ((cmd_bus.cmd_valid === 1'b1) && (prev_valid !== 1'b1)) rise_cnt <= rise_cnt + 1;
        if ((cmd_bus.cmd_valid === 1'b1) && (cmd_bus.cmd_ready === 1'b1) && (rst === 1'b1)) begin
            retire_cnt <= retire_cnt + 1;
            last_cmd   <= cmd_bus.cmd;
        end
        prev_valid <= cmd_bus.cmd_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame(input logic [2:0] c0, input logic [2:0] c1,
                         input logic [2:0] c2, input logic [2:0] c3);
        pr0 = c0; pr1 = c1; pr2 = c2; pr3 = c3;
        repeat (FRAME) @(negedge clk);
    endtask

    // Move to the first cycle of the top row
    task automatic align_frame();
        int n = 0;
        while (key_row !== ROW_BOT && n < 64) begin @(negedge clk); n++; end
        while (key_row !== ROW_TOP && n < 64) begin @(negedge clk); n++; end
        checks++;
        if (n >= 64) begin errors++; $display("FAIL align_frame got=%b exp=%b", key_row, ROW_TOP); end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        cmd_bus.cmd_ready = 1'b1;
        pr0 = 3'b000; pr1 = 3'b000; pr2 = 3'b000; pr3 = 3'b000;
        step(3);
        checks++; if (key_row !== 4'b1000) begin errors++; $display("FAIL reset_row got=%b exp=1000", key_row); end
        checks++; if (cmd_bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", cmd_bus.cmd_valid); end
        checks++; if (cmd_bus.cmd !== 3'd6) begin errors++; $display("FAIL reset_cmd got=%0d exp=6", cmd_bus.cmd); end
        checks++; if (key_value !== 4'hf) begin errors++; $display("FAIL reset_key_value got=%h exp=f", key_value); end
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL reset_key_held got=%b exp=0", key_held); end
        rst = 1'b1;
        step(3);
        checks++; if (key_row !== 4'b1000) begin errors++; $display("FAIL scan_row_3 got=%b exp=1000", key_row); end
        step(1);
        checks++; if (key_row !== 4'b0100) begin errors++; $display("FAIL scan_row_4 got=%b exp=0100", key_row); end
        step(11);
        checks++; if (key_row !== 4'b0001) begin errors++; $display("FAIL scan_row_15 got=%b exp=0001", key_row); end
        step(1);
        checks++; if (key_row !== 4'b1000) begin errors++; $display("FAIL scan_row_16 got=%b exp=1000", key_row); end
    endtask

    task automatic test_press_9();
        int r0, t0;
        align_frame();
        cmd_bus.cmd_ready = 1'b1;
        r0 = rise_cnt; t0 = retire_cnt;
        frame(3'b000, 3'b000, 3'b001, 3'b000);
        frame(3'b000, 3'b000, 3'b001, 3'b000);
        checks++; if (cmd_bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL p9_early_valid got=%b exp=0", cmd_bus.cmd_valid); end
        checks++; if (key_value !== 4'hf) begin errors++; $display("FAIL p9_early_key got=%h exp=f", key_value); end
        step(1);
        checks++; if (cmd_bus.cmd_valid !== 1'b1) begin errors++; $display("FAIL p9_valid got=%b exp=1", cmd_bus.cmd_valid); end
        checks++; if (cmd_bus.cmd !== CMD_RIGHT) begin errors++; $display("FAIL p9_cmd got=%0d exp=3", cmd_bus.cmd); end
        checks++; if (key_value !== 4'h9) begin errors++; $display("FAIL p9_key got=%h exp=9", key_value); end
        checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL p9_held got=%b exp=1", key_held); end
        step(1);
        checks++; if (cmd_bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL p9_retired_valid got=%b exp=0", cmd_bus.cmd_valid); end
        checks++; if (cmd_bus.cmd !== CMD_NONE) begin errors++; $display("FAIL p9_retired_cmd got=%0d exp=6", cmd_bus.cmd); end
        step(FRAME - 2);
        frame(3'b000, 3'b000, 3'b001, 3'b000);
        repeat (3) frame(3'b000, 3'b000, 3'b000, 3'b000);
        checks++; if (key_value !== 4'hf) begin errors++; $display("FAIL p9_release_key got=%h exp=f", key_value); end
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL p9_release_held got=%b exp=0", key_held); end
        checks++; if (rise_cnt - r0 !== 1) begin errors++; $display("FAIL p9_pulses got=%0d exp=1", rise_cnt - r0); end
        checks++; if (retire_cnt - t0 !== 1) begin errors++; $display("FAIL p9_retires got=%0d exp=1", retire_cnt - t0); end
        checks++; if (last_cmd !== CMD_RIGHT) begin errors++; $display("FAIL p9_last_cmd got=%0d exp=3", last_cmd); end
    endtask

    task automatic test_bounce();
        int r0;
        align_frame();
        r0 = rise_cnt;
        frame(3'b000, 3'b010, 3'b000, 3'b000);
        frame(3'b000, 3'b000, 3'b000, 3'b000);
        checks++; if (rise_cnt - r0 !== 0) begin errors++; $display("FAIL bounce_f2_pulses got=%0d exp=0", rise_cnt - r0); end
        checks++; if (key_value !== 4'hf) begin errors++; $display("FAIL bounce_f2_key got=%h exp=f", key_value); end
        frame(3'b000, 3'b010, 3'b000, 3'b000);
        frame(3'b000, 3'b010, 3'b000, 3'b000);
        checks++; if (cmd_bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL bounce_f4_valid got=%b exp=0", cmd_bus.cmd_valid); end
        step(1);
        checks++; if (cmd_bus.cmd_valid !== 1'b1) begin errors++; $display("FAIL bounce_valid got=%b exp=1", cmd_bus.cmd_valid); end
        checks++; if (cmd_bus.cmd !== CMD_UP) begin errors++; $display("FAIL bounce_cmd got=%0d exp=0", cmd_bus.cmd); end
        checks++; if (key_value !== 4'h5) begin errors++; $display("FAIL bounce_key got=%h exp=5", key_value); end
        step(FRAME - 1);
        repeat (3) frame(3'b000, 3'b000, 3'b000, 3'b000);
        checks++; if (rise_cnt - r0 !== 1) begin errors++; $display("FAIL bounce_pulses got=%0d exp=1", rise_cnt - r0); end
        checks++; if (key_value !== 4'hf) begin errors++; $display("FAIL bounce_release got=%h exp=f", key_value); end
    endtask

    task automatic test_backpressure();
        int r0, t0;
        align_frame();
        cmd_bus.cmd_ready = 1'b0;
        r0 = rise_cnt; t0 = retire_cnt;
        repeat (2) frame(3'b000, 3'b000, 3'b010, 3'b000);
        step(1);
        checks++; if (cmd_bus.cmd_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got=%b exp=1", cmd_bus.cmd_valid); end
        checks++; if (cmd_bus.cmd !== CMD_PUT) begin errors++; $display("FAIL bp_cmd got=%0d exp=2", cmd_bus.cmd); end
        step(FRAME - 1);
        repeat (3) frame(3'b000, 3'b000, 3'b000, 3'b000);
        checks++; if (key_value !== 4'hf) begin errors++; $display("FAIL bp_release_key got=%h exp=f", key_value); end
        checks++; if (cmd_bus.cmd !== CMD_PUT) begin errors++; $display("FAIL bp_release_cmd got=%0d exp=2", cmd_bus.cmd); end
        repeat (3) frame(3'b000, 3'b000, 3'b100, 3'b000);
        checks++; if (key_value !== 4'h7) begin errors++; $display("FAIL bp_key7 got=%h exp=7", key_value); end
        checks++; if (cmd_bus.cmd_valid !== 1'b1) begin errors++; $display("FAIL bp_held_valid got=%b exp=1", cmd_bus.cmd_valid); end
        checks++; if (cmd_bus.cmd !== CMD_PUT) begin errors++; $display("FAIL bp_held_cmd got=%0d exp=2", cmd_bus.cmd); end
        cmd_bus.cmd_ready = 1'b1;
        step(1);
        checks++; if (cmd_bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL bp_retire_valid got=%b exp=0", cmd_bus.cmd_valid); end
        checks++; if (cmd_bus.cmd !== CMD_NONE) begin errors++; $display("FAIL bp_retire_cmd got=%0d exp=6", cmd_bus.cmd); end
        checks++; if (last_cmd !== CMD_PUT) begin errors++; $display("FAIL bp_retired_code got=%0d exp=2", last_cmd); end
        step(FRAME - 1);
        repeat (2) frame(3'b000, 3'b000, 3'b100, 3'b000);
        checks++; if (rise_cnt - r0 !== 1) begin errors++; $display("FAIL bp_pulses got=%0d exp=1", rise_cnt - r0); end
        checks++; if (retire_cnt - t0 !== 1) begin errors++; $display("FAIL bp_retires got=%0d exp=1", retire_cnt - t0); end
        repeat (3) frame(3'b000, 3'b000, 3'b000, 3'b000);
    endtask

    task automatic test_priority_ignore();
        int r0;
        align_frame();
        cmd_bus.cmd_ready = 1'b1;
        repeat (2) frame(3'b000, 3'b010, 3'b000, 3'b010);
        step(1);
        checks++; if (cmd_bus.cmd_valid !== 1'b1) begin errors++; $display("FAIL prio_valid got=%b exp=1", cmd_bus.cmd_valid); end
        checks++; if (cmd_bus.cmd !== CMD_UP) begin errors++; $display("FAIL prio_cmd got=%0d exp=0", cmd_bus.cmd); end
        checks++; if (key_value !== 4'h5) begin errors++; $display("FAIL prio_key got=%h exp=5", key_value); end
        step(FRAME - 1);
        repeat (3) frame(3'b000, 3'b000, 3'b000, 3'b000);
        r0 = rise_cnt;
        repeat (3) frame(3'b100, 3'b000, 3'b000, 3'b000);
        checks++; if (key_value !== 4'h1) begin errors++; $display("FAIL key1_value got=%h exp=1", key_value); end
        checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL key1_held got=%b exp=1", key_held); end
        checks++; if (rise_cnt - r0 !== 0) begin errors++; $display("FAIL key1_pulses got=%0d exp=0", rise_cnt - r0); end
        repeat (3) frame(3'b000, 3'b000, 3'b000, 3'b000);
        repeat (3) frame(3'b000, 3'b110, 3'b000, 3'b000);
        checks++; if (key_value !== 4'hf) begin errors++; $display("FAIL multicol_key got=%h exp=f", key_value); end
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL multicol_held got=%b exp=0", key_held); end
        // Invalid top row must not mask a valid lower row
        repeat (2) frame(3'b110, 3'b000, 3'b010, 3'b000);
        step(1);
        checks++; if (cmd_bus.cmd_valid !== 1'b1) begin errors++; $display("FAIL multicol_8_valid got=%b exp=1", cmd_bus.cmd_valid); end
        checks++; if (cmd_bus.cmd !== CMD_PUT) begin errors++; $display("FAIL multicol_8_cmd got=%0d exp=2", cmd_bus.cmd); end
        step(FRAME - 1);
        repeat (3) frame(3'b000, 3'b000, 3'b000, 3'b000);
    endtask

    task automatic test_reset_mid_handshake();
        align_frame();
        cmd_bus.cmd_ready = 1'b0;
        repeat (2) frame(3'b000, 3'b000, 3'b010, 3'b000);
        step(1);
        checks++; if (cmd_bus.cmd_valid !== 1'b1) begin errors++; $display("FAIL rmid_pending got=%b exp=1", cmd_bus.cmd_valid); end
        rst = 1'b0;
        step(1);
        checks++; if (cmd_bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got=%b exp=0", cmd_bus.cmd_valid); end
        checks++; if (cmd_bus.cmd !== CMD_NONE) begin errors++; $display("FAIL rmid_cmd got=%0d exp=6", cmd_bus.cmd); end
        checks++; if (key_value !== 4'hf) begin errors++; $display("FAIL rmid_key got=%h exp=f", key_value); end
        checks++; if (key_row !== 4'b1000) begin errors++; $display("FAIL rmid_row got=%b exp=1000", key_row); end
        rst = 1'b1;
        cmd_bus.cmd_ready = 1'b1;
        step(2 * FRAME);
        checks++; if (cmd_bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL rmid_early got=%b exp=0", cmd_bus.cmd_valid); end
        step(1);
        checks++; if (cmd_bus.cmd_valid !== 1'b1) begin errors++; $display("FAIL rmid_reissue_valid got=%b exp=1", cmd_bus.cmd_valid); end
        checks++; if (cmd_bus.cmd !== CMD_PUT) begin errors++; $display("FAIL rmid_reissue_cmd got=%0d exp=2", cmd_bus.cmd); end
        checks++; if (key_value !== 4'h8) begin errors++; $display("FAIL rmid_reissue_key got=%h exp=8", key_value); end
        step(1);
        checks++; if (cmd_bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL rmid_retire got=%b exp=0", cmd_bus.cmd_valid); end
    endtask

    initial begin
        test_reset();
        test_press_9();
        test_bounce();
        test_backpressure();
        test_priority_ignore();
        test_reset_mid_handshake();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
